// File: rtl/wb_host_master_if.sv
// Signal bundle for wb_host_master: command/response channels and Wishbone master bus.
// Names are kept from the host master's point of view (_i into the master, _o out of it).
interface wb_host_master_if;
  // Command channel
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;

  // Response channel
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  // Wishbone classic master side
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-beat initiator: one bus cycle per command, IDLE -> BUS -> RESP.
// Optional ack timeout enabled by defining WBM_TIMEOUT_EN.
module wb_host_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_host_master_if.master   bus,
  output logic               busy_o,
  output logic [CNT_W-1:0]   txn_cnt_o,
  output logic [1:0]         state_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [31:0]        adr_q;
  logic [31:0]        dat_q;
  logic [3:0]         sel_q;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_fire;
  logic               tmo_hit;

`ifdef WBM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               rsp_err_q, rsp_err_d;

  // tmo_q counts completed ack-less BUS cycles; the TIMEOUT_CYCLES-th one aborts.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and payload is held stable while valid is high.
  assign cmd_fire = (state_q == ST_IDLE) && bus.cmd_valid_i;

  always_comb begin
    state_d   = state_q;
    rsp_dat_d = rsp_dat_q;
    cnt_d     = cnt_q;
`ifdef WBM_TIMEOUT_EN
    tmo_d     = tmo_q;
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          state_d = ST_BUS;
`ifdef WBM_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        if (bus.wbm_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
          state_d   = ST_RESP;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
        end else if (tmo_hit) begin
          rsp_dat_d = 32'h0;
          state_d   = ST_RESP;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d = 1'b1;
`endif
        end else begin
`ifdef WBM_TIMEOUT_EN
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      rsp_dat_q <= 32'h0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rsp_dat_q <= rsp_dat_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef WBM_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  // Command payload is captured once at acceptance so the bus sees it frozen for the cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q  <= 1'b0;
      adr_q <= 32'h0;
      dat_q <= 32'h0;
      sel_q <= 4'h0;
    end else if (cmd_fire) begin
      we_q  <= bus.cmd_we_i;
      adr_q <= bus.cmd_adr_i & 32'hFFFF_FFFC;
      dat_q <= bus.cmd_dat_i;
      sel_q <= bus.cmd_sel_i;
    end
  end

  // cyc/stb decode straight from the async-reset state so they fall as soon as reset asserts.
  assign bus.wbm_cyc_o   = (state_q == ST_BUS);
  assign bus.wbm_stb_o   = (state_q == ST_BUS);
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.wbm_sel_o   = sel_q;

  assign bus.cmd_ready_o = (state_q == ST_IDLE);
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_dat_o   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

  assign busy_o    = (state_q != ST_IDLE);
  assign txn_cnt_o = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed + randomized bench for wb_host_master with a transaction-level reference model.
module tb_wb_host_master;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] txn_cnt;
  logic [1:0]       state;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               exp_done = 0;
  logic [31:0]      exp_q[$];

  wb_host_master_if bus();

  wb_host_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .busy_o    (busy),
    .txn_cnt_o (txn_cnt),
    .state_o   (state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h0;
    bus.cmd_dat_i   = 32'h0;
    bus.cmd_sel_i   = 4'h0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_dat_i   = 32'h0;
    bus.wbm_ack_i   = 1'b0;
  endtask

  task automatic junk_cmd();
    bus.cmd_we_i  = 1'($urandom_range(0, 1));
    bus.cmd_adr_i = $urandom();
    bus.cmd_dat_i = $urandom();
    bus.cmd_sel_i = 4'($urandom_range(0, 15));
  endtask

  // One full transaction; wait_c = wait states before ack (large = never acks).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wait_c, input logic [31:0] rdata,
                         input int hold);
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_rsp;
    int          stb_cnt;
    logic        held_ok;

    exp_stb = wait_c + 1;
    exp_err = 1'b0;
`ifdef WBM_TIMEOUT_EN
    if (wait_c + 1 > TMO) begin
      exp_stb = TMO;
      exp_err = 1'b1;
    end
`endif
    exp_q.push_back((we || exp_err) ? 32'h0 : rdata);

    check("cmd_ready_idle", {31'h0, bus.cmd_ready_o}, 32'h1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    tick();
    bus.cmd_valid_i = 1'b0;
    junk_cmd();

    check("bus_cyc_first", {30'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h3);
    check("bus_adr", bus.wbm_adr_o, {adr[31:2], 2'b00});
    check("bus_we", {31'h0, bus.wbm_we_o}, {31'h0, we});
    check("bus_dat", bus.wbm_dat_o, dat);
    check("bus_sel", {28'h0, bus.wbm_sel_o}, {28'h0, sel});
    check("busy_bus", {31'h0, busy}, 32'h1);

    stb_cnt = 0;
    held_ok = 1'b1;
    while (bus.wbm_cyc_o === 1'b1 && stb_cnt < 64) begin
      stb_cnt++;
      if (bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== {adr[31:2], 2'b00} ||
          bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel || bus.wbm_we_o !== we ||
          bus.cmd_ready_o !== 1'b0)
        held_ok = 1'b0;
      bus.wbm_ack_i = (stb_cnt == wait_c + 1);
      bus.wbm_dat_i = bus.wbm_ack_i ? rdata : $urandom();
      tick();
    end
    bus.wbm_ack_i = 1'b0;

    check("stb_cycles", stb_cnt, exp_stb);
    check("bus_stable", {31'h0, held_ok}, 32'h1);
    exp_rsp = exp_q.pop_front();
    check("rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
    check("rsp_dat", bus.rsp_dat_o, exp_rsp);
    check("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, exp_err});

    bus.cmd_valid_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
      check("hold_dat", bus.rsp_dat_o, exp_rsp);
      check("hold_no_cmd", {30'h0, bus.cmd_ready_o, bus.wbm_cyc_o}, 32'h0);
    end
    bus.cmd_valid_i = 1'b0;

    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    exp_done++;
    check("rsp_consumed", {30'h0, bus.rsp_valid_o, busy}, 32'h0);
    check("cmd_ready_back", {31'h0, bus.cmd_ready_o}, 32'h1);
    check("txn_cnt", {{(32-CNT_W){1'b0}}, txn_cnt}, 32'(exp_done % (1 << CNT_W)));
  endtask

  // Stimulus
  initial begin
    drive_idle();
    #1;
    check("rst_cyc_stb", {30'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
    check("rst_we_sel", {27'h0, bus.wbm_we_o, bus.wbm_sel_o}, 32'h0);
    check("rst_adr", bus.wbm_adr_o, 32'h0);
    check("rst_wdat", bus.wbm_dat_o, 32'h0);
    check("rst_rsp", {29'h0, bus.rsp_valid_o, bus.rsp_err_o, busy}, 32'h0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("rst_cnt", {{(32-CNT_W){1'b0}}, txn_cnt}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", {31'h0, bus.cmd_ready_o}, 32'h1);

    // Write with two wait states, then zero-wait read with unaligned address
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, $urandom(), 0);
    run_txn(1'b0, 32'h3000_0013, $urandom(), 4'hF, 0, 32'hDEAD_BEEF, 0);
    // Response back-pressure for 5 cycles with a new command pending
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h3, 1, 32'h1234_5678, 5);

`ifdef WBM_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1000, 32'hCAFE_F00D, 1);
    run_txn(1'b0, 32'h0000_0204, 32'h0, 4'hF, TMO - 1, 32'hCAFE_F00D, 0);
`endif

    // Reset in the middle of a bus cycle
    bus.cmd_valid_i = 1'b1;
    junk_cmd();
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    check("pre_rst_cyc", {31'h0, bus.wbm_cyc_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_cyc_stb", {30'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
    check("midrst_rsp_busy", {30'h0, bus.rsp_valid_o, busy}, 32'h0);
    check("midrst_cnt", {{(32-CNT_W){1'b0}}, txn_cnt}, 32'h0);
    exp_done = 0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Stray ack while idle
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = $urandom();
    tick();
    bus.wbm_ack_i = 1'b0;
    check("stray_ack_state", {28'h0, state, bus.wbm_cyc_o, bus.rsp_valid_o}, 32'h0);
    check("stray_ack_cnt", {{(32-CNT_W){1'b0}}, txn_cnt}, 32'h0);

    // 17 random transactions: counter wraps 15 -> 0 and ends at 1
    for (int n = 0; n < 17; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom(), $urandom_range(0, 2));
    end
    check("final_cnt", {{(32-CNT_W){1'b0}}, txn_cnt}, 32'h1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
